// File: rtl/admo_muldiv.sv
// Iterative RV32M multiply/divide unit: one result bit per cycle, shift-add multiply
// and restoring divide on a shared 2*XLEN accumulator, sign fix-up in a final cycle.
module admo_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            md_valid,
    output logic            md_ready,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] md_a,
    input  logic [XLEN-1:0] md_b,
    input  logic            md_kill,
    output logic            md_done,
    output logic [XLEN-1:0] md_res
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     b_q;
    logic [2*XLEN-1:0]   acc_q;
    logic                neg_q;
    logic [XLEN-1:0]     res_q;
    logic                done_q;

    logic                a_signed, b_signed, a_neg, b_neg, sign_d;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                div_zero, div_ovf, special;
    logic [XLEN-1:0]     special_res;
    logic [XLEN:0]       mul_sum, div_trial;
    logic [2*XLEN-1:0]   acc_d;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quot_fix, rem_fix, fix_res_d;

    // Operand conditioning at issue time
    always_comb begin
        a_signed    = (md_op == 3'd0) || (md_op == 3'd1) || (md_op == 3'd2) ||
                      (md_op == 3'd4) || (md_op == 3'd6);
        b_signed    = (md_op == 3'd0) || (md_op == 3'd1) ||
                      (md_op == 3'd4) || (md_op == 3'd6);
        a_neg       = a_signed && md_a[XLEN-1];
        b_neg       = b_signed && md_b[XLEN-1];
        a_mag       = a_neg ? (~md_a + 1'b1) : md_a;
        b_mag       = b_neg ? (~md_b + 1'b1) : md_b;
        // Remainder takes the dividend's sign; everything else the product of signs.
        sign_d      = (md_op[2] && md_op[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero    = md_op[2] && (md_b == '0);
        div_ovf     = ((md_op == 3'd4) || (md_op == 3'd6)) &&
                      (md_a == INT_MIN) && (md_b == '1);
        special     = div_zero || div_ovf;
        special_res = '0;
        if (div_zero) begin
            special_res = md_op[1] ? md_a : '1;
        end else if (div_ovf) begin
            special_res = md_op[1] ? '0 : md_a;
        end
    end

    // One iteration: multiplier/dividend bits are consumed from the low half.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
        if (op_q[2]) begin
            acc_d = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                    : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    always_comb begin
        prod_fix  = neg_q ? (~acc_q + 1'b1) : acc_q;
        quot_fix  = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_fix   = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
        fix_res_d = '0;
        case (op_q)
            3'd0:         fix_res_d = prod_fix[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:         fix_res_d = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:   fix_res_d = quot_fix;
            default:      fix_res_d = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (md_valid && !md_kill) begin
                        op_q  <= md_op;
                        b_q   <= b_mag;
                        acc_q <= {{XLEN{1'b0}}, a_mag};
                        neg_q <= sign_d;
                        cnt_q <= '0;
                        if (special) begin
                            res_q   <= special_res;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (md_kill) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        acc_q <= acc_d;
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= FIX;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                FIX: begin
                    if (md_kill) begin
                        state_q <= IDLE;
                    end else begin
                        res_q   <= fix_res_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign md_ready = (state_q == IDLE);
    assign md_done  = done_q;
    assign md_res   = res_q;

endmodule

// File: tb/tb_admo_muldiv.sv
// Scoreboard bench for admo_muldiv: directed ops push expected result and done edge;
// a negedge monitor pops and compares on every md_done pulse.
module tb_admo_muldiv;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            md_valid;
    logic            md_ready;
    logic [2:0]      md_op;
    logic [XLEN-1:0] md_a;
    logic [XLEN-1:0] md_b;
    logic            md_kill;
    logic            md_done;
    logic [XLEN-1:0] md_res;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    logic [XLEN-1:0] exp_q[$];
    int              due_q[$];
    string           name_q[$];

    admo_muldiv #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .md_valid(md_valid), .md_ready(md_ready),
        .md_op(md_op), .md_a(md_a), .md_b(md_b), .md_kill(md_kill),
        .md_done(md_done), .md_res(md_res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (md_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got res %h at edge %0d, expected no done", md_res, edge_cnt);
            end else begin
                automatic logic [XLEN-1:0] e = exp_q.pop_front();
                automatic int d = due_q.pop_front();
                automatic string n = name_q.pop_front();
                check(n, md_res, e);
                check({n, "_latency"}, XLEN'(edge_cnt), XLEN'(d));
                $display("txn %s res=%h expected=%h edge=%0d", n, md_res, e, edge_cnt);
            end
        end
    end

    task automatic run_op(input string name, input logic [2:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input bit special);
        int k;
        bit rdy_bad;
        @(negedge clk);
        md_valid = 1'b1;
        md_op    = op;
        md_a     = a;
        md_b     = b;
        @(negedge clk);
        k = edge_cnt;
        exp_q.push_back(exp);
        due_q.push_back(special ? k : k + XLEN + 1);
        name_q.push_back(name);
        md_valid = 1'b0;
        md_op    = 3'($urandom);
        md_a     = $urandom;
        md_b     = $urandom;
        rdy_bad  = 1'b0;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            if (md_ready !== 1'b0) rdy_bad = 1'b1;
            @(negedge clk);
        end
        check({name, "_ready_low"}, XLEN'(rdy_bad), '0);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done within 100 cycles, expected done", name);
            exp_q.delete();
            due_q.delete();
            name_q.delete();
        end
    endtask

    initial begin
        rst = 1'b1; md_valid = 1'b0; md_kill = 1'b0; md_op = '0; md_a = '0; md_b = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", XLEN'(md_ready), 1);
        check("reset_done", XLEN'(md_done), 0);
        check("reset_res", md_res, '0);
        rst = 1'b0;

        run_op("mul_7_m3",     3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
        run_op("mulhu_ff_ff",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        run_op("mulh_m1_m1",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        run_op("mulhsu_m1_2",  3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0);
        run_op("div_m20_3",    3'd4, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 1'b0);
        run_op("rem_m20_3",    3'd6, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 1'b0);
        run_op("divu_100_7",   3'd5, 32'd100,      32'd7,        32'd14,       1'b0);
        run_op("remu_100_7",   3'd7, 32'd100,      32'd7,        32'd2,        1'b0);
        run_op("divu_by0",     3'd5, 32'h1234,     32'd0,        32'hFFFFFFFF, 1'b1);
        run_op("remu_by0",     3'd7, 32'h1234,     32'd0,        32'h1234,     1'b1);
        run_op("div_ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        run_op("rem_ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        run_op("div_by0",      3'd4, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFFF, 1'b1);

        // Kill a DIV when the iteration counter reads 10.
        @(negedge clk);
        md_valid = 1'b1; md_op = 3'd4; md_a = 32'd1000; md_b = 32'd3;
        @(negedge clk);
        md_valid = 1'b0;
        repeat (10) @(negedge clk);
        md_kill = 1'b1;
        @(negedge clk);
        md_kill = 1'b0;
        check("kill_ready", XLEN'(md_ready), 1);
        check("kill_res_held", md_res, 32'hFFFFFFFF);
        repeat (40) @(negedge clk);
        run_op("mul_6_7", 3'd0, 32'd6, 32'd7, 32'd42, 1'b0);

        // Reset in the middle of CALC.
        @(negedge clk);
        md_valid = 1'b1; md_op = 3'd0; md_a = 32'd5; md_b = 32'd5;
        @(negedge clk);
        md_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_ready", XLEN'(md_ready), 1);
        check("rst_mid_done", XLEN'(md_done), 0);
        check("rst_mid_res", md_res, '0);
        repeat (40) @(negedge clk);

        // Valid together with kill in IDLE must not be accepted.
        md_valid = 1'b1; md_kill = 1'b1; md_op = 3'd0; md_a = 32'd3; md_b = 32'd3;
        @(negedge clk);
        md_valid = 1'b0; md_kill = 1'b0;
        check("valid_kill_ready", XLEN'(md_ready), 1);
        repeat (40) @(negedge clk);

        run_op("mulhu_2p31_4", 3'd3, 32'h80000000, 32'd4, 32'd2, 1'b0);
        repeat (3) @(negedge clk);
        check("res_held", md_res, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
